// File: rtl/logic_pkg.sv
// Shared definitions for the logic issue stage and the ALU logic unit.
package logic_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned OPT_W = 4;

  // Logic-opcode encodings shared with the ALU logic unit
  localparam logic [OPT_W-1:0] LOGIC_AND = 4'd0;
  localparam logic [OPT_W-1:0] LOGIC_XOR = 4'd1;
  localparam logic [OPT_W-1:0] LOGIC_OR  = 4'd2;
  localparam logic [OPT_W-1:0] LOGIC_ILL = 4'd15;

  // RV64 opcode / funct fields
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;

  // Bundle handed to the ALU logic unit
  typedef struct packed {
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [OPT_W-1:0] opt;
    logic             illegal;
  } logic_bundle_t;

  // Skid buffer occupancy
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  // Map funct3 to a logic opcode; unsupported funct3 yields LOGIC_ILL
  function automatic logic [OPT_W-1:0] funct3_to_opt(input logic [2:0] f3);
    logic [OPT_W-1:0] opt;
    opt = LOGIC_ILL;
    case (f3)
      F3_AND:  opt = LOGIC_AND;
      F3_XOR:  opt = LOGIC_XOR;
      F3_OR:   opt = LOGIC_OR;
      default: opt = LOGIC_ILL;
    endcase
    return opt;
  endfunction

endpackage

// File: rtl/logic_issue_dec.sv
// Combinational decoder: instruction + register values -> logic bundle.
// Optional immediate forms (andi/xori/ori) enabled by LOGIC_ISSUE_IMM_EN.
module logic_issue_dec
  import logic_pkg::*;
(
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic_bundle_t   bundle_c
);

  logic [6:0]       opcode;
  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic [OPT_W-1:0] f3_opt;
  logic             unused_bits;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign f3_opt = funct3_to_opt(funct3);

  // Register-index and rd fields carry no information for this stage
  assign unused_bits = ^{inst[24:15], inst[11:7]};

  // Classify; anything unrecognised is flagged illegal with operands passed through
  always_comb begin
    bundle_c.src1    = rs1_data;
    bundle_c.src2    = rs2_data;
    bundle_c.opt     = LOGIC_ILL;
    bundle_c.illegal = 1'b1;
    if (opcode == OPC_OP && funct7 == F7_BASE && f3_opt != LOGIC_ILL) begin
      bundle_c.opt     = f3_opt;
      bundle_c.illegal = 1'b0;
    end
`ifdef LOGIC_ISSUE_IMM_EN
    else if (opcode == OPC_OP_IMM && f3_opt != LOGIC_ILL) begin
      bundle_c.opt     = f3_opt;
      bundle_c.illegal = 1'b0;
      bundle_c.src2    = {{(XLEN-12){inst[31]}}, inst[31:20]};
    end
`endif
  end

endmodule

// File: rtl/logic_issue.sv
// Issue stage for the ALU logic unit: decode plus a two-entry skid buffer.
// Optional feature macro: LOGIC_ISSUE_IMM_EN (immediate logic forms).
module logic_issue
  import logic_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_src1,
  output logic [XLEN-1:0]  out_src2,
  output logic [OPT_W-1:0] out_opt,
  output logic             out_illegal
);

  buf_state_t    state;
  logic_bundle_t dec_c;
  logic_bundle_t main_q;
  logic_bundle_t skid_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          in_fire;
  logic          out_fire;

  logic_issue_dec u_dec (
    .inst     (in_inst),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .bundle_c (dec_c)
  );

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Buffer occupancy, payload registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q      <= dec_c;
            out_valid_q <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= dec_c;
          end else if (in_fire) begin
            skid_q     <= dec_c;
            in_ready_q <= 1'b0;
            state      <= ST_TWO;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            state       <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_src1    = main_q.src1;
  assign out_src2    = main_q.src2;
  assign out_opt     = main_q.opt;
  assign out_illegal = main_q.illegal;

endmodule

// File: doc/logic_issue.md
# logic_issue

Issue stage for the ALU logic unit: accepts a decoded-register-read bundle (instruction word plus rs1/rs2 values) under valid/ready, classifies the RV64 logic instructions, and emits the `src1`/`src2`/4-bit logic-opcode bundle the ALU logic unit consumes. It sits between register read and the ALU. It provides one cycle of latency and a two-entry skid buffer, so `in_ready` is a registered signal and full throughput is sustained while `out_ready` stays high.

## Interface
- `XLEN`, 64, operand width
- `OPT_W`, 4, logic-opcode width
- `clk  input  1  clock; all state updates on rising edge`
- `rst_n  input  1  reset, asynchronous, active-low`
- `in_valid  input  1  upstream bundle valid`
- `in_ready  output  1  stage can accept; registered`
- `in_inst  input  32  instruction word`
- `in_rs1_data  input  XLEN  rs1 value`
- `in_rs2_data  input  XLEN  rs2 value`
- `out_valid  output  1  bundle to ALU valid`
- `out_ready  input  1  ALU accepts`
- `out_src1  output  XLEN  operand 1`
- `out_src2  output  XLEN  operand 2`
- `out_opt  output  OPT_W  0=and, 1=xor, 2=or, 15=illegal`
- `out_illegal  output  1  instruction is not a supported logic op`

## Operation
- Decode (combinational, on the input side):
  - opcode `0110011` with funct7 `0000000`: funct3 `111`→0, `100`→1, `110`→2; `src2` = `in_rs2_data`.
  - Every other encoding: `opt`=15, `illegal`=1, `src1`/`src2` are passed through unchanged.
- The bundle {`src1`, `src2`, `opt`, `illegal`} is stored in the main register (drives the outputs) or in the skid register.
- Transfer: an input transfer occurs when `in_valid & in_ready`; an output transfer occurs when `out_valid & out_ready`.
- Buffer states:
  - EMPTY: `out_valid`=0.
  - ONE: main valid, skid empty.
  - TWO: both valid.
- Transitions:
  - EMPTY + in → ONE.
  - ONE + in + out → ONE; the new bundle goes to main.
  - ONE + in, no out → TWO; the new bundle goes to skid.
  - ONE + out only → EMPTY.
  - TWO + out → ONE; skid moves to main.
  - TWO: no input is accepted.
- `in_ready` = registered (state != TWO).
- Output stability: while `out_valid & ~out_ready`, all `out_*` signals hold stable.

## Timing
- Reset (async assert, sync deassert by the clock domain):
  - state=EMPTY, `in_ready`=1, `out_valid`=0.
  - `out_src1`=`out_src2`=0, `out_opt`=0, `out_illegal`=0.
  - Skid contents are cleared.
- Reset mid-operation: both buffered bundles are dropped and none is ever emitted.
- Latency: an input accepted in cycle N appears with `out_valid`=1 in cycle N+1, provided the stage was EMPTY, or ONE with an output transfer in cycle N.
- Throughput: one bundle per cycle while `out_ready`=1.
- `in_ready` falls the cycle after entering TWO. It rises the cycle after the first output transfer from TWO.
- Simultaneous in/out transfers in ONE never cause a bubble.
- Order is strictly FIFO.

## Configuration
- `LOGIC_ISSUE_IMM_EN`
  - Defined: opcode `0010011` (andi/xori/ori) is decoded with the same funct3 map. `src2` = `in_inst[31:20]` sign-extended to XLEN, and `in_rs2_data` is ignored.
  - Undefined: opcode `0010011` is illegal (`opt`=15, `illegal`=1).

## Structure
- Shared package (`logic_pkg`):
  - Opcode constants `LOGIC_AND`=0, `LOGIC_XOR`=1, `LOGIC_OR`=2, `LOGIC_ILL`=15; the ALU logic unit uses the same values.
  - RV opcode/funct3 constants.
  - Bundle typedef {`src1`, `src2`, `opt`, `illegal`}.
- Sub-module `logic_issue_dec`: the pure combinational decoder (inst, rs1, rs2 → bundle). The skid/state logic lives in `logic_issue`.

## Test plan
- Single issue: `in_inst`=0x0020F1B3 (`and` x3,x1,x2), rs1=0xF0F0, rs2=0xFF00, `out_ready`=1.
  - Next cycle: `out_valid`=1, `opt`=0, `src1`=0xF0F0, `src2`=0xFF00, `illegal`=0.
- Backpressure: hold `out_ready`=0 and present 3 back-to-back bundles.
  - Exactly 2 are accepted.
  - `in_ready`=0 from the 3rd cycle.
  - After `out_ready`=1, the outputs appear in order with no duplication.
- Immediate form: `in_inst`=0xFFF34293 (`xori` x5,x6,-1).
  - With the macro: `opt`=1, `src2`=0xFFFF_FFFF_FFFF_FFFF.
  - Without the macro: `opt`=15, `illegal`=1.
- Illegal case: `in_inst`=0x002081B3 (`add`) → `opt`=15, `illegal`=1; the bundle is still delivered.
- Streaming: 100 random bundles with random `in_valid`/`out_ready`.
  - A scoreboard matches order and contents.
  - With both held high for 10 cycles, 10 transfers occur.
- Reset mid-operation: assert `rst_n`=0 in state TWO.
  - Immediately: `out_valid`=0 and all `out_*`=0.
  - After release: `in_ready`=1, and no stale bundle is emitted.
